mem_bus_stage: RTL and testbench
================================

Name: mem_bus_stage

Overview:
- MEM-stage data-memory access unit. Sits between ex_mem and mem_wb and produces the mem_* result signals that mem_wb registers.
- Performs byte, halfword and word loads/stores, plus LL/SC, over a req/ack data bus using a small FSM.
- Raises stallreq to ctrl until the access completes and holds the captured load data while the pipeline is frozen.
- Handles flush in the middle of an access and a bus watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of cycles waiting in BUSY before the access is abandoned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_i  in  6  ctrl stall vector; stall_i[3]=Stop freezes ex_mem.
- flush_i  in  1  pipeline flush from ctrl.
- wd_i / wreg_i / wdata_i  in  5/1/32  destination register, write enable and ALU result from ex_mem.
- hi_i / lo_i / whilo_i  in  32/32/1  HI/LO values and write enable, passed through.
- aluop_i  in  8  opcode; uses the shared EXE_LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC codes.
- mem_addr_i / reg2_i  in  32/32  effective address and store data.
- LLbit_i  in  1  committed LLbit from LLbit_reg.
- wb_LLbit_we_i / wb_LLbit_value_i  in  1/1  LLbit forwarded from mem_wb.
- bus_rdata_i / bus_ack_i  in  32/1  bus read data and acknowledge.
- bus_req_o / bus_we_o  out  1/1  request and write strobe.
- bus_addr_o / bus_sel_o / bus_wdata_o  out  32/4/32  word address, byte lanes, write data.
- wd_o / wreg_o / wdata_o  out  5/1/32  to mem_wb.
- hi_o / lo_o / whilo_o  out  32/32/1  to mem_wb.
- LLbit_we_o / LLbit_value_o  out  1/1  to mem_wb.
- stallreq_o  out  1  stall request to ctrl.
- bus_err_o  out  1  one-cycle pulse on timeout.

Behaviour:
- While rst=1: state=IDLE, rdata_q=0, timer=0, and every output is 0 (wd_o=NOPRegAddr).
- memop = aluop_i is a load or store; SC counts only when LLbit is 1.
- LLbit = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i.
- Big-endian lanes:
  - byte: addr[1:0]=00→sel 1000 (data [31:24]); 01→0100; 10→0010; 11→0001.
  - halfword: addr[1]=0→1100; addr[1]=1→0011. addr[0] is ignored.
  - word: sel 1111.
- bus_addr_o = {mem_addr_i[31:2],2'b00}.
- bus_wdata_o replicates reg2_i's byte or halfword across all lanes; word stores drive reg2_i unchanged.
- Loads: selected lane is sign-extended (LB, LH) or zero-extended (LBU, LHU). LW/LL take the full word.
- LL: LLbit_we_o=1, LLbit_value_o=1.
- SC with LLbit=1: store issued; wdata_o=1; LLbit_we_o=1, LLbit_value_o=0.
- SC with LLbit=0: no bus access, wdata_o=0, wreg_o=1, LLbit_we_o=0.
- Non-memory ops: all mem_* inputs pass through combinationally; no bus activity.
- FSM states:
  - IDLE: bus_req_o = memop (combinational). If bus_ack_i arrives the same cycle → HOLD; else if memop → BUSY.
  - BUSY: bus_req_o=1; timer increments. On bus_ack_i → HOLD and capture bus_rdata_i into rdata_q. On timer=TIMEOUT_CYCLES-1 → HOLD with rdata_q=0 and bus_err_o pulsed for one cycle.
  - HOLD: bus_req_o=0; load result is taken from rdata_q. Stay while stall_i[3]=Stop; → IDLE when stall_i[3]=NoStop.
  - ABORT: bus_req_o=1 and outputs held at NOP. On ack or timeout → IDLE; captured data is discarded.
- stallreq_o = memop && state∈{IDLE,BUSY} && !bus_ack_i, or a new memop present while state=ABORT.
- On the ack cycle, load data is taken from bus_rdata_i directly, so completion costs zero extra cycles.
- Flush:
  - flush_i in IDLE or HOLD → IDLE.
  - flush_i in BUSY without ack that cycle → ABORT, because the bus cannot be cancelled.
  - flush_i together with ack → IDLE.
- A store never reissues: HOLD blocks a second request for the same frozen instruction.
- Reset asserted mid-access → IDLE immediately and bus_req_o drops asynchronously.

Decomposition:
- Shared defines header: aluop load/store codes, RstEnable, Stop/NoStop, ZeroWord, NOPRegAddr, RegBus, RegAddrBus.
- FSM state encodings stay local.
- Optional sub-module mem_lane_align: combinational sel, wdata replication and load extraction/extension. The FSM and timer remain in the top.

Test Plan:
- LB at 0x1003, one-cycle ack, rdata 0x112233F0 → sel 0001, addr 0x1000, wdata_o=0xFFFFFFF0, stallreq_o high for 1 cycle.
- SH reg2 0x0000ABCD at 0x2002, ack after 3 cycles → bus_wdata_o=0xABCDABCD, sel 0011; stallreq_o high for 3 cycles then low; exactly one request.
- LL at 0x40 followed by SC with LLbit 1 → LL sets LLbit_we_o/LLbit_value_o=1/1; SC writes and returns wdata_o=1, LLbit_value_o=0. SC with LLbit 0 → no bus_req_o, wdata_o=0.
- LW acked while stall_i[3]=Stop for 4 cycles → state HOLD, bus_req_o=0, wdata_o stays rdata_q; → IDLE when stall releases.
- flush_i during BUSY, ack 2 cycles later → ABORT; outputs NOP; following LW stalled until ABORT ends.
- No ack for 255 cycles → bus_err_o single pulse, wdata_o=0, stallreq_o released.

Source files
------------

// File: rtl/mem_bus_stage_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit: control
// constants, bus widths and the aluop codes for loads and stores.
package mem_bus_stage_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  function automatic logic is_load_op(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SC_OP};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: byte select, store data replication and
// load extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_bus_stage_pkg::*;
(
  input  logic [7:0]        aluop,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] store_data,
  input  logic [RegBus-1:0] load_word,
  output logic [3:0]        sel,
  output logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] load_data
);

  logic [7:0]  lane_byte [4];
  logic [7:0]  byte_pick;
  logic [15:0] half_pick;
  logic [3:0]  byte_lanes;
  logic [3:0]  half_lanes;

  // Split the bus word into byte lanes; lane 3 is the most significant byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = load_word[8*gi +: 8];
    end
  endgenerate

  // Address 00 maps to the top lane, so the lane index is the inverted offset.
  assign byte_pick  = lane_byte[~addr_lo];
  assign half_pick  = addr_lo[1] ? load_word[15:0] : load_word[31:16];
  assign byte_lanes = 4'b1000 >> addr_lo;
  assign half_lanes = addr_lo[1] ? 4'b0011 : 4'b1100;

  // Per-opcode lane selection, store replication and load extension.
  always_comb begin
    sel       = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (aluop)
      EXE_LB_OP: begin
        sel       = byte_lanes;
        load_data = {{24{byte_pick[7]}}, byte_pick};
      end
      EXE_LBU_OP: begin
        sel       = byte_lanes;
        load_data = {24'b0, byte_pick};
      end
      EXE_LH_OP: begin
        sel       = half_lanes;
        load_data = {{16{half_pick[15]}}, half_pick};
      end
      EXE_LHU_OP: begin
        sel       = half_lanes;
        load_data = {16'b0, half_pick};
      end
      EXE_SB_OP: begin
        sel   = byte_lanes;
        wdata = {4{store_data[7:0]}};
      end
      EXE_SH_OP: begin
        sel   = half_lanes;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_stage.sv
// MEM-stage data-memory access unit. Issues loads/stores (incl. LL/SC) over a
// req/ack bus, stalls the pipeline until the access completes, holds captured
// load data while frozen, and copes with flush mid-access and bus timeouts.
module mem_bus_stage
  import mem_bus_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall_i,
  input  logic                  flush_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic [7:0]            aluop_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic                  LLbit_i,
  input  logic                  wb_LLbit_we_i,
  input  logic                  wb_LLbit_value_i,
  input  logic [RegBus-1:0]     bus_rdata_i,
  input  logic                  bus_ack_i,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [RegBus-1:0]     bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [RegBus-1:0]     bus_wdata_o,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  LLbit_we_o,
  output logic                  LLbit_value_o,
  output logic                  stallreq_o,
  output logic                  bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, ABORT} state_t;

  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [TimerW-1:0]   timer_reg, timer_next;
  logic [RegBus-1:0]   rdata_reg, rdata_next;
  logic                bus_err_next;

  logic                llbit, is_load, is_store, is_sc, memop, timed_out, bus_req_now;
  logic [3:0]          lane_sel;
  logic [RegBus-1:0]   lane_wdata, lane_load, load_word;

  // Only the ex_mem freeze bit matters here; the other stall bits are ignored.
  logic unused_stall;
  assign unused_stall = &{1'b0, stall_i[5:4], stall_i[2:0]};

  assign llbit     = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
  assign is_load   = is_load_op(aluop_i);
  assign is_store  = is_store_op(aluop_i);
  assign is_sc     = (aluop_i == EXE_SC_OP);
  // A failed SC never touches the bus.
  assign memop     = is_load | (is_store & (~is_sc | llbit));
  assign timed_out = (timer_reg == TimerLast);
  // Once HOLD is reached the same frozen instruction never requests again.
  assign bus_req_now = (state_reg == IDLE)  ? memop :
                       (state_reg == BUSY) || (state_reg == ABORT);
  // On the ack cycle data comes straight off the bus; afterwards from the capture.
  assign load_word = (state_reg == HOLD) ? rdata_reg : bus_rdata_i;

  mem_lane_align u_lane (
    .aluop      (aluop_i),
    .addr_lo    (mem_addr_i[1:0]),
    .store_data (reg2_i),
    .load_word  (load_word),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // State, watchdog timer and captured load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      rdata_reg <= ZeroWord;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      rdata_reg <= rdata_next;
    end
  end

  // Next-state logic: access sequencing, flush handling and watchdog.
  always_comb begin
    state_next   = state_reg;
    timer_next   = '0;
    rdata_next   = rdata_reg;
    bus_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush_i) begin
          state_next = IDLE;
        end else if (memop && bus_ack_i) begin
          state_next = HOLD;
          rdata_next = bus_rdata_i;
        end else if (memop) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        timer_next = timer_reg + TimerW'(1);
        if (bus_ack_i) begin
          rdata_next = bus_rdata_i;
          timer_next = '0;
          state_next = flush_i ? IDLE : HOLD;
        end else if (timed_out) begin
          rdata_next   = ZeroWord;
          bus_err_next = 1'b1;
          timer_next   = '0;
          state_next   = flush_i ? IDLE : HOLD;
        end else if (flush_i) begin
          // The bus cannot be cancelled, so wait out the orphaned access.
          state_next = ABORT;
        end
      end
      HOLD: begin
        if (flush_i || stall_i[3] == NoStop) begin
          state_next = IDLE;
        end
      end
      ABORT: begin
        timer_next = timer_reg + TimerW'(1);
        if (bus_ack_i || timed_out) begin
          timer_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus drive and mem_wb results; everything is forced to zero during reset.
  always_comb begin
    bus_req_o     = 1'b0;
    bus_we_o      = 1'b0;
    bus_addr_o    = ZeroWord;
    bus_sel_o     = 4'b0000;
    bus_wdata_o   = ZeroWord;
    wd_o          = NOPRegAddr;
    wreg_o        = 1'b0;
    wdata_o       = ZeroWord;
    hi_o          = ZeroWord;
    lo_o          = ZeroWord;
    whilo_o       = 1'b0;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    stallreq_o    = 1'b0;
    bus_err_o     = 1'b0;
    if (rst != RstEnable) begin
      bus_req_o = bus_req_now;
      if (bus_req_now) begin
        bus_we_o    = is_store;
        bus_addr_o  = {mem_addr_i[31:2], 2'b00};
        bus_sel_o   = lane_sel;
        bus_wdata_o = lane_wdata;
      end
      stallreq_o = memop && ((((state_reg == IDLE) || (state_reg == BUSY)) && !bus_ack_i) ||
                             (state_reg == ABORT));
      bus_err_o  = bus_err_next;
      if (state_reg != ABORT) begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = is_load ? lane_load : wdata_i;
        hi_o    = hi_i;
        lo_o    = lo_i;
        whilo_o = whilo_i;
        if (aluop_i == EXE_LL_OP) begin
          LLbit_we_o    = 1'b1;
          LLbit_value_o = 1'b1;
        end
        if (is_sc) begin
          wreg_o  = 1'b1;
          wdata_o = llbit ? 32'd1 : ZeroWord;
          if (llbit) begin
            LLbit_we_o    = 1'b1;
            LLbit_value_o = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_stage.sv
// Directed bench for mem_bus_stage: loads/stores of every width, LL/SC,
// freeze in HOLD, flush into ABORT, watchdog timeout and async reset.
module tb_mem_bus_stage;
  import mem_bus_stage_pkg::*;

  logic        clk, rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic        LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o, LLbit_we_o, LLbit_value_o, stallreq_o, bus_err_o;

  int n_checks;
  int n_fail;
  int first_err;
  int pulses;

  localparam logic [5:0] StallMem = 6'b001111;

  mem_bus_stage #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    aluop_i    = op;
    mem_addr_i = addr;
    reg2_i     = r2;
    wd_i       = wd;
    wreg_i     = wreg;
    wdata_i    = wdata;
  endtask

  task automatic nop();
    set_op(8'h00, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_1111);
  endtask

  // Zero-wait access acked in IDLE, then one HOLD cycle, then back to a NOP.
  task automatic quick(input string tag, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] r2, input logic [31:0] rdata, input logic [3:0] exp_sel,
                       input logic [31:0] exp_bwd, input logic [31:0] exp_wdata);
    @(negedge clk);
    set_op(op, addr, r2, 5'd2, 1'b1, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = rdata;
    #1;
    chk32({tag, "_sel"}, 32'(bus_sel_o), 32'(exp_sel));
    chk32({tag, "_bwdata"}, bus_wdata_o, exp_bwd);
    chk32({tag, "_wdata"}, wdata_o, exp_wdata);
    chk1({tag, "_stall"}, stallreq_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk1({tag, "_hold_req"}, bus_req_o, 1'b0);
    chk32({tag, "_hold_wdata"}, wdata_o, exp_wdata);
    @(negedge clk);
    nop();
    $display("[%0t] %s addr=%08h sel=%b wdata_o=%08h", $time, tag, addr, exp_sel, exp_wdata);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; stall_i = 6'b0; flush_i = 1'b0;
    set_op(EXE_LW_OP, 32'h1000, 32'h5, 5'd9, 1'b1, 32'h77);
    hi_i = 32'hAAAA_0000; lo_i = 32'h0000_5555; whilo_i = 1'b1;
    LLbit_i = 1'b1; wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
    bus_rdata_i = 32'h1234_5678; bus_ack_i = 1'b1;

    // Reset state
    #2;
    chk1("rst_req", bus_req_o, 1'b0);
    chk32("rst_wd", 32'(wd_o), 32'h0);
    chk32("rst_wdata", wdata_o, 32'h0);
    chk32("rst_hi", hi_o, 32'h0);
    chk1("rst_stall", stallreq_o, 1'b0);
    chk1("rst_llwe", LLbit_we_o, 1'b0);
    $display("[%0t] reset asserted", $time);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; bus_ack_i = 1'b0; nop();
    #1;
    chk32("nop_wd", 32'(wd_o), 32'd3);
    chk32("nop_wdata", wdata_o, 32'h0000_1111);
    chk32("nop_hi", hi_o, 32'hAAAA_0000);
    chk1("nop_whilo", whilo_o, 1'b1);
    chk1("nop_req", bus_req_o, 1'b0);
    $display("[%0t] NOP passthrough", $time);

    // LB at 0x1003, acked on the first BUSY cycle
    @(negedge clk);
    set_op(EXE_LB_OP, 32'h1003, 32'h0, 5'd4, 1'b1, 32'h0);
    #1;
    chk1("lb_req", bus_req_o, 1'b1);
    chk32("lb_sel", 32'(bus_sel_o), 32'h1);
    chk32("lb_addr", bus_addr_o, 32'h1000);
    chk1("lb_we", bus_we_o, 1'b0);
    chk1("lb_stall0", stallreq_o, 1'b1);
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1122_33F0;
    #1;
    chk32("lb_wdata_ack", wdata_o, 32'hFFFF_FFF0);
    chk1("lb_stall1", stallreq_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk1("lb_hold_req", bus_req_o, 1'b0);
    chk32("lb_hold_wdata", wdata_o, 32'hFFFF_FFF0);
    @(negedge clk);
    nop();
    #1;
    chk1("lb_after_req", bus_req_o, 1'b0);
    $display("[%0t] LB @1003 -> FFFFFFF0", $time);

    // SH at 0x2002, ack on the 4th request cycle
    @(negedge clk);
    set_op(EXE_SH_OP, 32'h2002, 32'h0000_ABCD, 5'd0, 1'b0, 32'h2004);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      bus_ack_i = (c == 3);
      #1;
      chk1("sh_req", bus_req_o, 1'b1);
      chk1("sh_we", bus_we_o, 1'b1);
      chk32("sh_sel", 32'(bus_sel_o), 32'h3);
      chk32("sh_bwdata", bus_wdata_o, 32'hABCD_ABCD);
      chk1("sh_stall", stallreq_o, c < 3);
    end
    chk32("sh_wdata_pass", wdata_o, 32'h2004);
    @(negedge clk);
    bus_ack_i = 1'b0; stall_i = StallMem;
    #1;
    chk1("sh_hold_req0", bus_req_o, 1'b0);
    chk1("sh_hold_stall", stallreq_o, 1'b0);
    @(negedge clk);
    #1;
    chk1("sh_hold_req1", bus_req_o, 1'b0);
    @(negedge clk);
    stall_i = 6'b0;
    #1;
    chk1("sh_hold_req2", bus_req_o, 1'b0);
    @(negedge clk);
    nop();
    $display("[%0t] SH @2002 bus_wdata=ABCDABCD sel=0011", $time);

    // LL at 0x40, zero-wait
    @(negedge clk);
    set_op(EXE_LL_OP, 32'h40, 32'h0, 5'd8, 1'b1, 32'h0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk1("ll_req", bus_req_o, 1'b1);
    chk32("ll_sel", 32'(bus_sel_o), 32'hF);
    chk32("ll_addr", bus_addr_o, 32'h40);
    chk1("ll_llwe", LLbit_we_o, 1'b1);
    chk1("ll_llval", LLbit_value_o, 1'b1);
    chk32("ll_wdata", wdata_o, 32'hDEAD_BEEF);
    chk1("ll_stall", stallreq_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    #1;
    chk32("ll_hold_wdata", wdata_o, 32'hDEAD_BEEF);
    $display("[%0t] LL @40 -> DEADBEEF", $time);

    // SC with LLbit=1 via mem_wb forwarding
    @(negedge clk);
    set_op(EXE_SC_OP, 32'h44, 32'h1234_5678, 5'd8, 1'b1, 32'h0);
    LLbit_i = 1'b0; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
    #1;
    chk1("sc1_req", bus_req_o, 1'b1);
    chk1("sc1_we", bus_we_o, 1'b1);
    chk32("sc1_bwdata", bus_wdata_o, 32'h1234_5678);
    chk1("sc1_stall", stallreq_o, 1'b1);
    chk32("sc1_wdata", wdata_o, 32'h1);
    chk1("sc1_llwe", LLbit_we_o, 1'b1);
    chk1("sc1_llval", LLbit_value_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b1;
    #1;
    chk1("sc1_stall_ack", stallreq_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk1("sc1_hold_req", bus_req_o, 1'b0);
    $display("[%0t] SC @44 LLbit=1 -> stored, wdata_o=1", $time);

    // SC with LLbit=0 (forwarded value overrides committed 1)
    @(negedge clk);
    LLbit_i = 1'b1; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
    #1;
    chk1("sc0_req", bus_req_o, 1'b0);
    chk32("sc0_wdata", wdata_o, 32'h0);
    chk1("sc0_wreg", wreg_o, 1'b1);
    chk1("sc0_llwe", LLbit_we_o, 1'b0);
    chk1("sc0_stall", stallreq_o, 1'b0);
    @(negedge clk);
    wb_LLbit_we_i = 1'b0; LLbit_i = 1'b0;
    #1;
    chk1("sc0_req2", bus_req_o, 1'b0);
    $display("[%0t] SC @44 LLbit=0 -> no bus access, wdata_o=0", $time);

    // LW acked while the pipeline is frozen
    @(negedge clk);
    set_op(EXE_LW_OP, 32'h80, 32'h0, 5'd10, 1'b1, 32'h0);
    stall_i = StallMem; bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
    #1;
    chk32("lw_wdata_ack", wdata_o, 32'hCAFE_F00D);
    chk1("lw_stall_ack", stallreq_o, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_ack_i = 1'b0; bus_rdata_i = 32'h5555_5555;
      #1;
      chk1("lw_hold_req", bus_req_o, 1'b0);
      chk32("lw_hold_wdata", wdata_o, 32'hCAFE_F00D);
      chk1("lw_hold_stall", stallreq_o, 1'b0);
    end
    @(negedge clk);
    stall_i = 6'b0;
    #1;
    chk32("lw_release_wdata", wdata_o, 32'hCAFE_F00D);
    @(negedge clk);
    nop();
    #1;
    chk1("lw_idle_req", bus_req_o, 1'b0);
    chk32("lw_idle_wdata", wdata_o, 32'h0000_1111);
    $display("[%0t] LW @80 frozen 4 cycles -> CAFEF00D", $time);

    // Lane coverage for remaining widths
    quick("lhu", EXE_LHU_OP, 32'h3002, 32'h0, 32'h1234_8001, 4'b0011, 32'h0, 32'h0000_8001);
    quick("lh", EXE_LH_OP, 32'h3000, 32'h0, 32'h8001_1234, 4'b1100, 32'h0, 32'hFFFF_8001);
    quick("lbu", EXE_LBU_OP, 32'h3001, 32'h0, 32'h00FF_0000, 4'b0100, 32'h0, 32'h0000_00FF);
    quick("sb", EXE_SB_OP, 32'h5001, 32'h0000_00A5, 32'h0, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    quick("sw", EXE_SW_OP, 32'h6000, 32'hCAFE_BABE, 32'h0, 4'b1111, 32'hCAFE_BABE, 32'h0);

    // Flush during BUSY, the orphaned access is acked two cycles later
    @(negedge clk);
    set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0);
    #1;
    chk1("fl_stall0", stallreq_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk1("fl_stall1", stallreq_o, 1'b1);
    @(negedge clk);
    flush_i = 1'b0;
    set_op(EXE_LW_OP, 32'h200, 32'h0, 5'd7, 1'b1, 32'h0);
    #1;
    chk32("fl_abort_wd", 32'(wd_o), 32'h0);
    chk1("fl_abort_wreg", wreg_o, 1'b0);
    chk1("fl_abort_req", bus_req_o, 1'b1);
    chk1("fl_abort_stall", stallreq_o, 1'b1);
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_9999;
    #1;
    chk32("fl_abort_wdata", wdata_o, 32'h0);
    chk1("fl_abort_stall_ack", stallreq_o, 1'b1);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk1("fl_new_req", bus_req_o, 1'b1);
    chk1("fl_new_stall", stallreq_o, 1'b1);
    chk32("fl_new_wd", 32'(wd_o), 32'd7);
    chk32("fl_new_addr", bus_addr_o, 32'h200);
    @(negedge clk);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D;
    #1;
    chk32("fl_new_wdata", wdata_o, 32'h0BAD_F00D);
    chk1("fl_new_stall_ack", stallreq_o, 1'b0);
    @(negedge clk);
    bus_ack_i = 1'b0;
    #1;
    chk32("fl_hold_wdata", wdata_o, 32'h0BAD_F00D);
    @(negedge clk);
    nop();
    $display("[%0t] flush mid-LW -> ABORT, next LW @200 -> 0BADF00D", $time);

    // Watchdog: no ack at all
    @(negedge clk);
    set_op(EXE_LW_OP, 32'h300, 32'h0, 5'd5, 1'b1, 32'h0);
    first_err = -1; pulses = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus_err_o) begin
        pulses++;
        if (first_err < 0) first_err = i;
      end
      if (i == 255) chk1("to_stall_last", stallreq_o, 1'b1);
    end
    chk32("to_first_cycle", 32'(first_err), 32'd255);
    chk32("to_pulses", 32'(pulses), 32'd1);
    @(negedge clk);
    #1;
    chk1("to_hold_err", bus_err_o, 1'b0);
    chk32("to_hold_wdata", wdata_o, 32'h0);
    chk1("to_hold_stall", stallreq_o, 1'b0);
    chk1("to_hold_req", bus_req_o, 1'b0);
    @(negedge clk);
    nop();
    $display("[%0t] LW @300 timeout -> bus_err at cycle %0d", $time, first_err);

    // Reset in the middle of an access
    @(negedge clk);
    set_op(EXE_LW_OP, 32'h400, 32'h0, 5'd5, 1'b1, 32'h0);
    #1;
    chk1("ra_req", bus_req_o, 1'b1);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk1("ra_req_async", bus_req_o, 1'b0);
    chk1("ra_stall_async", stallreq_o, 1'b0);
    chk32("ra_wd_async", 32'(wd_o), 32'h0);
    @(negedge clk);
    rst = 1'b0; nop();
    #1;
    chk1("ra_idle_req", bus_req_o, 1'b0);
    $display("[%0t] reset mid-LW -> bus_req dropped", $time);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
